// File: rtl/spr_linebuf_if.sv
// Scan-out bus of the sprite line buffer: timing strobes and renderer writes in,
// display pixels and status out. The timing generator/renderer side is the master.
interface spr_linebuf_if #(
    parameter int PIX_W = 12,
    parameter int AW    = 8
);
    logic             PIX_CE;
    logic             LINE_START;
    logic             HBLANK;
    logic             WR_EN;
    logic [AW-1:0]    WR_ADDR;
    logic [PIX_W-1:0] WR_DATA;
    logic [PIX_W-1:0] PIX_OUT;
    logic             PIX_VALID;
    logic             BUF_SEL;
    logic             CLR_ERR;

    modport master (
        output PIX_CE, LINE_START, HBLANK, WR_EN, WR_ADDR, WR_DATA,
        input  PIX_OUT, PIX_VALID, BUF_SEL, CLR_ERR
    );

    modport slave (
        input  PIX_CE, LINE_START, HBLANK, WR_EN, WR_ADDR, WR_DATA,
        output PIX_OUT, PIX_VALID, BUF_SEL, CLR_ERR
    );
endinterface

// File: rtl/spr_linebuf.sv
// Double-buffered sprite line buffer with clear-behind scan-out.
// Define SPR_LINEBUF_FLIP_EN to scan and clear in descending address order.
module spr_linebuf #(
    parameter int LB_WIDTH = 256,
    parameter int PIX_W    = 12
) (
    input  logic         clk,
    input  logic         nRESET,
    spr_linebuf_if.slave bus
);
    localparam int AW = $clog2(LB_WIDTH);

    typedef enum logic [1:0] {ST_WAIT, ST_SCAN, ST_CLEAR} state_t;

    state_t           state_q;
    logic [AW-1:0]    rd_cnt_q;
    logic             buf_sel_q;
    logic             clr_err_q;
    logic             hblank_q;

    // Pipeline: stage 1 holds the read request, stage 2 the RAM word, stage 3 the outputs.
    logic             slot1_q;
    logic             rd_req_q;
    logic [AW-1:0]    rd_addr_q;
    logic             rd_sel_q;
    logic             slot2_q;
    logic             val2_q;
    logic             sel2_q;
    logic [PIX_W-1:0] pix_out_q;
    logic             pix_valid_q;

    logic [AW-1:0]    eff_addr;
    logic             rd_fire;
    logic             clr_sweep;
    logic             rnd_we;
    logic             front_we;
    logic [AW-1:0]    front_waddr;
    logic             at_end;
    logic             hblank_rise;
    logic [PIX_W-1:0] ram_rd_sel;

`ifdef SPR_LINEBUF_FLIP_EN
    assign eff_addr = AW'(LB_WIDTH - 1) - rd_cnt_q;
`else
    assign eff_addr = rd_cnt_q;
`endif

    assign at_end      = (rd_cnt_q == AW'(LB_WIDTH - 1));
    assign hblank_rise = bus.HBLANK && !hblank_q;
    assign rd_fire     = (state_q == ST_SCAN) && bus.PIX_CE && !bus.HBLANK && !bus.LINE_START;
    assign clr_sweep   = (state_q == ST_CLEAR) && !bus.LINE_START;
    assign rnd_we      = bus.WR_EN && (bus.WR_DATA[3:0] != 4'd0);

    // Clear-behind of the previous read and the blanking sweep never overlap in one clk.
    assign front_we    = rd_req_q || clr_sweep;
    assign front_waddr = rd_req_q ? rd_addr_q : eff_addr;

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q   <= ST_WAIT;
            rd_cnt_q  <= '0;
            buf_sel_q <= 1'b0;
            clr_err_q <= 1'b0;
            hblank_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_sel_q  <= 1'b0;
        end else begin
            hblank_q <= bus.HBLANK;
            rd_req_q <= rd_fire;
            if (rd_fire) begin
                rd_addr_q <= eff_addr;
                rd_sel_q  <= buf_sel_q;
            end
            if (bus.LINE_START) begin
                buf_sel_q <= ~buf_sel_q;
                rd_cnt_q  <= '0;
                state_q   <= ST_SCAN;
                if (state_q != ST_WAIT) begin
                    clr_err_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_SCAN: begin
                        if (rd_fire) begin
                            if (at_end) begin
                                state_q <= ST_WAIT;
                            end else begin
                                rd_cnt_q <= rd_cnt_q + AW'(1);
                            end
                        end else if (hblank_rise && (rd_cnt_q != '0)) begin
                            state_q <= ST_CLEAR;
                        end
                    end
                    ST_CLEAR: begin
                        if (at_end) begin
                            state_q <= ST_WAIT;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + AW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM gi is the front buffer when BUF_SEL equals gi; the renderer owns the other one.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ram
            logic [PIX_W-1:0] mem [LB_WIDTH];
            logic [PIX_W-1:0] rd_q;
            logic             is_front;
            logic             we;
            logic [AW-1:0]    waddr;
            logic [PIX_W-1:0] wdata;

            assign is_front = (buf_sel_q == 1'(gi));
            assign we       = is_front ? front_we    : rnd_we;
            assign waddr    = is_front ? front_waddr : bus.WR_ADDR;
            assign wdata    = is_front ? '0          : bus.WR_DATA;

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
                if (rd_req_q) begin
                    rd_q <= mem[rd_addr_q];
                end
            end
        end
    endgenerate

    assign ram_rd_sel = sel2_q ? g_ram[1].rd_q : g_ram[0].rd_q;

    // Outputs advance only in PIX_CE slots, so they hold for the whole pixel period.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            slot1_q     <= 1'b0;
            slot2_q     <= 1'b0;
            val2_q      <= 1'b0;
            sel2_q      <= 1'b0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            slot1_q <= bus.PIX_CE;
            slot2_q <= slot1_q;
            val2_q  <= rd_req_q;
            sel2_q  <= rd_sel_q;
            if (slot2_q) begin
                pix_valid_q <= val2_q;
                pix_out_q   <= val2_q ? ram_rd_sel : '0;
            end
        end
    end

    assign bus.PIX_OUT   = pix_out_q;
    assign bus.PIX_VALID = pix_valid_q;
    assign bus.BUF_SEL   = buf_sel_q;
    assign bus.CLR_ERR   = clr_err_q;
endmodule

// File: tb/tb_spr_linebuf.sv
// Scoreboard bench for spr_linebuf: the stimulus pushes the expected pixel of every
// active read, a monitor pops it when the matching output slot shows a valid pixel.
module tb_spr_linebuf;
    localparam int LBW = 256;
    localparam int PW  = 12;
    localparam int AW  = 8;

    typedef struct {
        logic [PW-1:0] v;
        bit            care;
        int            px;
    } exp_t;

    logic clk = 1'b0;
    logic nRESET = 1'b0;
    always #5 clk = ~clk;

    spr_linebuf_if #(.PIX_W(PW), .AW(AW)) bus();

    spr_linebuf #(.LB_WIDTH(LBW), .PIX_W(PW)) dut (
        .clk    (clk),
        .nRESET (nRESET),
        .bus    (bus)
    );

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic [PW-1:0] line_exp [LBW];
    bit            care_en;
    int            line_no = 0;
    logic [2:0]    ce_hist = 3'b000;

    function automatic int px2addr(input int p);
`ifdef SPR_LINEBUF_FLIP_EN
        return LBW - 1 - p;
`else
        return p;
`endif
    endfunction

    task automatic chk(input string name, input int px, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s px=%0d got=%h want=%h", name, px, act, exp);
        end
    endtask

    // PIX_CE history as the DUT sampled it; bit 2 marks the clk whose outputs a CE produced.
    always @(posedge clk) ce_hist <= {ce_hist[1:0], bus.PIX_CE};

    always @(negedge clk) begin
        if (nRESET && ce_hist[2] && bus.PIX_VALID) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel got=%h want=none", bus.PIX_OUT);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.care) chk("pixel", e.px, bus.PIX_OUT, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < LBW; i++) line_exp[i] = '0;
    endtask

    task automatic wr(input int px, input logic [PW-1:0] data);
        bus.WR_ADDR = AW'(px2addr(px));
        bus.WR_DATA = data;
        bus.WR_EN   = 1'b1;
        tick();
        bus.WR_EN   = 1'b0;
        $display("write px=%0d addr=%0d data=%h", px, px2addr(px), data);
    endtask

    task automatic line_start(input bit with_wr, input int px, input logic [PW-1:0] data);
        bus.LINE_START = 1'b1;
        bus.WR_EN      = with_wr;
        bus.WR_ADDR    = AW'(px2addr(px));
        bus.WR_DATA    = data;
        tick();
        bus.LINE_START = 1'b0;
        bus.WR_EN      = 1'b0;
        $display("line_start buf_sel=%0d clr_err=%0d", bus.BUF_SEL, bus.CLR_ERR);
    endtask

    // Scans n active pixels with gap idle clks between PIX_CE pulses, then blanks.
    task automatic scan(input int n, input int gap);
        bus.HBLANK = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.v = line_exp[i];
            e.care = care_en;
            e.px = i;
            sb.push_back(e);
            bus.PIX_CE = 1'b1;
            tick();
            bus.PIX_CE = 1'b0;
            repeat (gap) tick();
        end
        bus.HBLANK = 1'b1;
        bus.PIX_CE = 1'b1;
        tick();
        bus.PIX_CE = 1'b0;
        tick();
        tick();
        chk("valid_drop", -1, PW'(bus.PIX_VALID), '0);
        $display("scan line=%0d pixels=%0d checked=%0d sb_left=%0d", line_no, n, care_en, sb.size());
        line_no++;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bus.PIX_CE = 1'b0;
        bus.LINE_START = 1'b1;
        bus.HBLANK = 1'b1;
        bus.WR_EN = 1'b0;
        bus.WR_ADDR = '0;
        bus.WR_DATA = '0;
        nRESET = 1'b0;
        repeat (3) tick();
        chk("rst_buf_sel", -1, PW'(bus.BUF_SEL), '0);
        chk("rst_pix_out", -1, bus.PIX_OUT, '0);
        chk("rst_pix_valid", -1, PW'(bus.PIX_VALID), '0);
        chk("rst_clr_err", -1, PW'(bus.CLR_ERR), '0);
        bus.LINE_START = 1'b0;
        nRESET = 1'b1;
        tick();

        // Flush power-up garbage from both buffers.
        care_en = 1'b0;
        clear_exp();
        line_start(0, 0, '0);
        scan(LBW, 0);
        line_start(0, 0, '0);
        scan(LBW, 0);
        care_en = 1'b1;
        chk("flush_buf_sel", -1, PW'(bus.BUF_SEL), '0);
        chk("flush_clr_err", -1, PW'(bus.CLR_ERR), '0);

        // Back buffer B: single pixel, transparent overwrite, later-wins, last address.
        wr(10, 12'h125);
        wr(20, 12'h347);
        wr(20, 12'h340);
        wr(30, 12'h111);
        wr(30, 12'h2A9);
        wr(255, 12'h0F8);
        line_start(1, 40, 12'h5C3);
        chk("swap1_buf_sel", -1, PW'(bus.BUF_SEL), PW'(1));
        wr(50, 12'h7A1);
        clear_exp();
        line_exp[10] = 12'h125;
        line_exp[20] = 12'h347;
        line_exp[30] = 12'h2A9;
        line_exp[40] = 12'h5C3;
        line_exp[255] = 12'h0F8;
        scan(LBW, 1);

        line_start(0, 0, '0);
        chk("swap2_buf_sel", -1, PW'(bus.BUF_SEL), '0);
        clear_exp();
        line_exp[50] = 12'h7A1;
        scan(LBW, 0);
        chk("full_clr_err", -1, PW'(bus.CLR_ERR), '0);

        // B was fully scanned: it must now read back as all transparent.
        line_start(0, 0, '0);
        wr(5, 12'h3F1);
        wr(240, 12'hDD2);
        clear_exp();
        scan(LBW, 0);

        // Partial line on A: the blanking sweep must clear the unread tail.
        line_start(0, 0, '0);
        wr(100, 12'hABC);
        wr(230, 12'h9E6);
        clear_exp();
        line_exp[5] = 12'h3F1;
        scan(224, 0);
        repeat (40) tick();
        chk("sweep_clr_err", -1, PW'(bus.CLR_ERR), '0);
        chk("sweep_buf_sel", -1, PW'(bus.BUF_SEL), '0);

        line_start(0, 0, '0);
        clear_exp();
        line_exp[100] = 12'hABC;
        line_exp[230] = 12'h9E6;
        scan(LBW, 0);

        line_start(0, 0, '0);
        clear_exp();
        scan(LBW, 0);

        // Swap during the blanking sweep flags an error and leaves the tail uncleared.
        wr(250, 12'hE17);
        line_start(0, 0, '0);
        clear_exp();
        scan(200, 0);
        tick();
        line_start(0, 0, '0);
        chk("early_swap_clr_err", -1, PW'(bus.CLR_ERR), PW'(1));
        chk("early_swap_buf_sel", -1, PW'(bus.BUF_SEL), '0);
        scan(LBW, 0);
        chk("sticky_clr_err1", -1, PW'(bus.CLR_ERR), PW'(1));
        line_start(0, 0, '0);
        line_exp[250] = 12'hE17;
        scan(LBW, 0);
        chk("sticky_clr_err2", -1, PW'(bus.CLR_ERR), PW'(1));

        nRESET = 1'b0;
        tick();
        tick();
        chk("rst2_clr_err", -1, PW'(bus.CLR_ERR), '0);
        chk("rst2_buf_sel", -1, PW'(bus.BUF_SEL), '0);
        chk("rst2_pix_valid", -1, PW'(bus.PIX_VALID), '0);
        chk("rst2_pix_out", -1, bus.PIX_OUT, '0);
        chk("sb_drain", -1, PW'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
